// File: rtl/serial_pattern_transmitter_if.sv
// -----------------------------------------------------------------------------
// serial_pattern_transmitter_if
// Bundles the load handshake and the serial output of the pattern transmitter.
//   load_data  [WIDTH] : word to transmit, bit WIDTH-1 goes out first
//   load_valid         : source has a word on load_data
//   load_ready         : transmitter accepts a word this cycle
//   sout               : serial data bit (0 whenever sout_valid=0)
//   sout_valid         : sout carries a frame bit this cycle
//   frame_done         : high on the cycle carrying the last bit of a frame
// Modports: master = word source / bit consumer, slave = transmitter.
// -----------------------------------------------------------------------------
interface serial_pattern_transmitter_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_done;

  modport master (
    output load_data, load_valid,
    input  load_ready, sout, sout_valid, frame_done
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, sout, sout_valid, frame_done
  );
endinterface

// File: rtl/serial_pattern_transmitter.sv
// -----------------------------------------------------------------------------
// serial_pattern_transmitter
// Parallel-to-serial transmitter: takes a WIDTH-bit word over a valid/ready
// handshake and shifts it out MSB-first, one bit per clock, with a bit-valid
// qualifier and an end-of-frame pulse. GAP_CYCLES idle cycles follow each
// frame; GAP_CYCLES=0 lets a new word be accepted on the last-bit cycle so
// frames run back to back.
// Ports:
//   clk         : system clock, all state updates on posedge
//   rst_n       : synchronous active-low reset
//   bus (slave) : load_data/load_valid/load_ready, sout/sout_valid/frame_done
//   match       : (TX_PATTERN_COUNT_EN only) 1101 completed on this sout bit
//   match_count : (TX_PATTERN_COUNT_EN only) saturating 8-bit match counter
// Optional feature macro: TX_PATTERN_COUNT_EN adds an overlapping 1101
// tracker over the transmitted bits plus the match/match_count outputs.
// -----------------------------------------------------------------------------
module serial_pattern_transmitter #(
  parameter int WIDTH      = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  serial_pattern_transmitter_if.slave  bus
`ifdef TX_PATTERN_COUNT_EN
  ,
  output logic                         match,
  output logic [7:0]                   match_count
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : GAP_ZERO;
  localparam bit            NO_GAP   = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_sout_valid;
  logic             r_frame_done;
  logic             r_load_ready;
  logic             w_accept;

  // load_ready is registered, so a handshake is just valid & the ready flop
  assign w_accept = bus.load_valid & r_load_ready;

  // sout is the shift-register MSB; the register is all-zero outside a frame
  // (the last-bit edge shifts the final bit out), so sout is 0 when idle.
  assign bus.sout       = r_shift[WIDTH-1];
  assign bus.sout_valid = r_sout_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.load_ready = r_load_ready;

  // Transmit FSM with registered outputs; each flag is set for the cycle
  // the state being entered will occupy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= {WIDTH{1'b0}};
      r_bit_cnt    <= CNT_ZERO;
      r_gap_cnt    <= GAP_ZERO;
      r_sout_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_frame_done <= 1'b0;
          if (w_accept) begin
            r_shift      <= bus.load_data;
            r_bit_cnt    <= CNT_LAST;
            r_state      <= ST_SHIFT;
            r_sout_valid <= 1'b1;
            r_load_ready <= 1'b0;
          end else begin
            r_sout_valid <= 1'b0;
            r_load_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_bit_cnt != CNT_ZERO) begin
            r_shift      <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_cnt    <= r_bit_cnt - CNT_ONE;
            r_sout_valid <= 1'b1;
            // next cycle carries the last bit
            r_frame_done <= (r_bit_cnt == CNT_ONE);
            // with no gap, the last-bit cycle already offers ready
            r_load_ready <= NO_GAP && (r_bit_cnt == CNT_ONE);
          end else begin
            r_frame_done <= 1'b0;
            if (!NO_GAP) begin
              r_state      <= ST_GAP;
              r_gap_cnt    <= GAP_LAST;
              r_shift      <= {WIDTH{1'b0}};
              r_sout_valid <= 1'b0;
              r_load_ready <= 1'b0;
            end else if (w_accept) begin
              // back-to-back: next word starts with no bubble
              r_shift      <= bus.load_data;
              r_bit_cnt    <= CNT_LAST;
              r_sout_valid <= 1'b1;
              r_load_ready <= 1'b0;
            end else begin
              r_state      <= ST_IDLE;
              r_shift      <= {WIDTH{1'b0}};
              r_sout_valid <= 1'b0;
              r_load_ready <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          r_sout_valid <= 1'b0;
          r_frame_done <= 1'b0;
          if (r_gap_cnt == GAP_ZERO) begin
            r_state      <= ST_IDLE;
            r_load_ready <= 1'b1;
          end else begin
            r_gap_cnt    <= r_gap_cnt - GW'(1);
            r_load_ready <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_shift      <= {WIDTH{1'b0}};
          r_bit_cnt    <= CNT_ZERO;
          r_gap_cnt    <= GAP_ZERO;
          r_sout_valid <= 1'b0;
          r_frame_done <= 1'b0;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef TX_PATTERN_COUNT_EN
  typedef enum logic [1:0] {
    TK_S0   = 2'd0,
    TK_S1   = 2'd1,
    TK_S11  = 2'd2,
    TK_S110 = 2'd3
  } trk_t;

  // Overlapping 1101 tracker: after a match the trailing 1 seeds TK_S1
  function automatic trk_t trk_next(input trk_t s, input logic b);
    trk_t n;
    case (s)
      TK_S0:   n = b ? TK_S1  : TK_S0;
      TK_S1:   n = b ? TK_S11 : TK_S0;
      TK_S11:  n = b ? TK_S11 : TK_S110;
      TK_S110: n = b ? TK_S1  : TK_S0;
      default: n = TK_S0;
    endcase
    return n;
  endfunction

  trk_t       r_trk;
  logic       r_match;
  logic [7:0] r_match_count;

  assign match       = r_match;
  assign match_count = r_match_count;

  // r_trk holds the tracker state after the bit currently on sout; match is
  // computed one edge early from the bit about to be shown so it is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_trk         <= TK_S0;
      r_match       <= 1'b0;
      r_match_count <= 8'd0;
    end else begin
      if (r_match && (r_match_count != 8'hFF)) begin
        r_match_count <= r_match_count + 8'd1;
      end else begin
        r_match_count <= r_match_count;
      end
      if (w_accept) begin
        // new word restarts the tracker from its start state
        r_trk   <= trk_next(TK_S0, bus.load_data[WIDTH-1]);
        r_match <= 1'b0;
      end else if ((r_state == ST_SHIFT) && (r_bit_cnt != CNT_ZERO)) begin
        r_trk   <= trk_next(r_trk, r_shift[WIDTH-2]);
        r_match <= (r_trk == TK_S110) && r_shift[WIDTH-2];
      end else begin
        r_trk   <= TK_S0;
        r_match <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_pattern_transmitter.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_transmitter
// Two transmitters (GAP_CYCLES=1 and GAP_CYCLES=0) driven from schedules of
// words and request cycles. The reference model derives, from the protocol
// rules alone, the acceptance cycle of every word and from it the expected
// per-cycle ready/valid/sout/frame_done (and 1101 matches when the optional
// counter is built).
// -----------------------------------------------------------------------------
module tb_serial_pattern_transmitter;
  localparam int W    = 16;
  localparam int MAXC = 600;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_pattern_transmitter_if #(.WIDTH(W)) bus0 ();
  serial_pattern_transmitter_if #(.WIDTH(W)) bus1 ();

`ifdef TX_PATTERN_COUNT_EN
  logic       m0, m1;
  logic [7:0] mc0, mc1;
`endif

  serial_pattern_transmitter #(.WIDTH(W), .GAP_CYCLES(0)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
`ifdef TX_PATTERN_COUNT_EN
    , .match (m0), .match_count (mc0)
`endif
  );

  serial_pattern_transmitter #(.WIDTH(W), .GAP_CYCLES(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
`ifdef TX_PATTERN_COUNT_EN
    , .match (m1), .match_count (mc1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] wq[$];
  int           rq[$];
  logic [3:0]   eo[MAXC];   // {load_ready, sout_valid, sout, frame_done}
  bit           em[MAXC];
  int           ecnt[MAXC];

  function automatic logic [3:0] obs(input int sel);
    if (sel == 0) return {bus0.load_ready, bus0.sout_valid, bus0.sout, bus0.frame_done};
    else          return {bus1.load_ready, bus1.sout_valid, bus1.sout, bus1.frame_done};
  endfunction

`ifdef TX_PATTERN_COUNT_EN
  function automatic logic obs_m(input int sel);
    return (sel == 0) ? m0 : m1;
  endfunction
  function automatic logic [7:0] obs_mc(input int sel);
    return (sel == 0) ? mc0 : mc1;
  endfunction
`endif

  task automatic drive(input int sel, input logic v, input logic [W-1:0] d);
    bus0.load_valid = 1'b0; bus0.load_data = W'($urandom);
    bus1.load_valid = 1'b0; bus1.load_data = W'($urandom);
    if (sel == 0) begin bus0.load_valid = v; bus0.load_data = d; end
    else          begin bus1.load_valid = v; bus1.load_data = d; end
  endtask

  // leaves the bench at the negedge of the first cycle after reset
  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Model: source k raises valid at max(rq[k], previous accept + 1) and holds
  // the word until accepted. A word is accepted once the previous frame frees
  // the transmitter: accept+W (last-bit cycle) with no gap, or
  // accept+W+gap+1 (first idle cycle) otherwise.
  task automatic run_timeline(input int sel, input bit rst_first);
    int gap;
    int acc[$];
    int rr[$];
    int prev_a;
    int a;
    int r;
    int fr;
    int h;
    int c;
    logic [W-1:0] wd;
    logic [3:0] got;
    logic v;
    logic [W-1:0] d;
    gap = (sel == 0) ? 0 : 1;
    prev_a = 0;
    for (int k = 0; k < wq.size(); k++) begin
      r = rq[k];
      if (k > 0 && r < prev_a + 1) r = prev_a + 1;
      a = r;
      if (k > 0) begin
        fr = (gap > 0) ? prev_a + W + gap + 1 : prev_a + W;
        if (a < fr) a = fr;
      end
      rr.push_back(r);
      acc.push_back(a);
      prev_a = a;
    end
    h = prev_a + W + gap + 3;
    if (h > MAXC) begin
      n_err++;
      $display("FAIL timeline_length got=%0d limit=%0d", h, MAXC);
      $fatal(1, "timeline too long");
    end
    for (int i = 0; i < MAXC; i++) begin eo[i] = 4'b1000; em[i] = 1'b0; end
    for (int k = 0; k < acc.size(); k++) begin
      wd = wq[k];
      for (int i = 1; i <= W; i++) begin
        c = acc[k] + i;
        eo[c] = {(i == W) && (gap == 0), 1'b1, wd[W-i], (i == W)};
        if (i >= 4 && wd[W-i+3] && wd[W-i+2] && !wd[W-i+1] && wd[W-i]) em[c] = 1'b1;
      end
      for (int g = 1; g <= gap; g++) eo[acc[k] + W + g] = 4'b0000;
    end
    ecnt[0] = 0;
    for (int i = 1; i < MAXC; i++) begin
      ecnt[i] = ecnt[i-1] + int'(em[i-1]);
      if (ecnt[i] > 255) ecnt[i] = 255;
    end

    if (rst_first) do_reset();
    for (int cy = 0; cy < h; cy++) begin
      got = obs(sel);
      n_vec++;
      if (got !== eo[cy]) begin
        n_err++;
        $display("FAIL stream sel=%0d cyc=%0d got{rdy,vld,sout,fd}=%b exp=%b", sel, cy, got, eo[cy]);
      end
`ifdef TX_PATTERN_COUNT_EN
      n_vec++;
      if (obs_m(sel) !== em[cy] || obs_mc(sel) !== 8'(ecnt[cy])) begin
        n_err++;
        $display("FAIL match sel=%0d cyc=%0d got m=%b cnt=%0d exp m=%b cnt=%0d",
                 sel, cy, obs_m(sel), obs_mc(sel), em[cy], ecnt[cy]);
      end
`endif
      v = 1'b0;
      d = W'($urandom);
      for (int k = 0; k < acc.size(); k++) begin
        if (rr[k] <= cy && cy <= acc[k]) begin v = 1'b1; d = wq[k]; end
      end
      drive(sel, v, d);
      @(negedge clk);
    end
    drive(sel, 1'b0, '0);
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst_n = 1'b0;
    drive(0, 1'b1, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, '0);
    for (int s = 0; s < 2; s++) begin
      got = obs(s);
      n_vec++;
      if (got !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_state sel=%0d got{rdy,vld,sout,fd}=%b exp=1000", s, got);
      end
`ifdef TX_PATTERN_COUNT_EN
      n_vec++;
      if (obs_m(s) !== 1'b0 || obs_mc(s) !== 8'd0) begin
        n_err++;
        $display("FAIL reset_match sel=%0d got m=%b cnt=%0d exp 0/0", s, obs_m(s), obs_mc(s));
      end
`endif
    end
  endtask

  task automatic test_pattern();
    wq = '{16'b1101101101101101}; rq = '{0};
    run_timeline(1, 1'b1);
  endtask

  task automatic test_back_to_back();
    wq = '{16'hFFFF, 16'h0000}; rq = '{0, 0};
    run_timeline(0, 1'b1);
    wq = '{16'hDDDD, 16'hDDDD}; rq = '{0, 0};
    run_timeline(1, 1'b1);
    run_timeline(0, 1'b1);
  endtask

  task automatic test_busy_ignore();
    wq = '{16'h1234, 16'hAAAA}; rq = '{0, 3};
    run_timeline(1, 1'b1);
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w;
    logic [3:0]  got;
    logic [3:0]  exp;
    w = 16'hD00D;
    do_reset();
    drive(1, 1'b1, w);
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      got = obs(1);
      exp = {1'b0, 1'b1, w[W-i], 1'b0};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL midrst_bits bit=%0d got=%b exp=%b", i, got, exp);
      end
      if (i == 5) rst_n = 1'b0;
      drive(1, 1'b0, '0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      got = obs(1);
      n_vec++;
      if (got !== 4'b1000) begin
        n_err++;
        $display("FAIL midrst_after cyc=%0d got=%b exp=1000", i, got);
      end
`ifdef TX_PATTERN_COUNT_EN
      n_vec++;
      if (obs_mc(1) !== 8'd0) begin
        n_err++;
        $display("FAIL midrst_count cyc=%0d got=%0d exp=0", i, obs_mc(1));
      end
`endif
      @(negedge clk);
    end
    wq = '{16'hD00D}; rq = '{2};
    run_timeline(1, 1'b0);
  endtask

  task automatic test_random();
    int t;
    for (int s = 0; s < 2; s++) begin
      for (int rep = 0; rep < 3; rep++) begin
        wq.delete(); rq.delete();
        t = 0;
        for (int k = 0; k < 8; k++) begin
          t += $urandom_range(0, 25);
          wq.push_back(W'($urandom));
          rq.push_back(t);
        end
        run_timeline(s, 1'b1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, '0);
    test_reset();
    test_pattern();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
